// File: rtl/dbg_bus_pkg.sv
// Shared encodings for the debug bus master: command ops, response status
// bytes and the controller state type.
package dbg_bus_pkg;

    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    localparam logic [7:0] ST_ACK = 8'h06;
    localparam logic [7:0] ST_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS,
        RESP
    } state_e;

    // A command is usable only with at least one byte lane and a read/write op.
    function automatic logic cmd_valid(input logic [7:0] cmd);
        return (cmd[7:4] != 4'h0) && ((cmd[1:0] == OP_WR) || (cmd[1:0] == OP_RD));
    endfunction

endpackage

// File: rtl/dbg_bus_master.sv
// Byte-stream controlled bus initiator: parses cmd/address/data frames from
// the byte receiver, runs one stb/ack bus cycle and streams back a status
// byte (plus read data) through the byte transmitter handshake.
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR  | collecting 4 address bytes, MSB first
// WDATA | collecting 4 write-data bytes, MSB first (writes only)
// BUS   | stb_o held, waiting for ack_i or the ack timeout
// RESP  | sending status byte, then 4 read-data bytes on a good read
module dbg_bus_master
    import dbg_bus_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT   = 1024,     // must be >= 2
    parameter int unsigned FRAME_TIMEOUT = 2500000   // must be >= 2
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        stb_o,
    input  logic        ack_i,
    output logic        busy_o,
    output logic        rx_ovr_o
);

    localparam int AW = $clog2(ACK_TIMEOUT);
    localparam int FW = $clog2(FRAME_TIMEOUT);
    localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_TIMEOUT - 1);
    localparam logic [FW-1:0] FRM_LOAD = FW'(FRAME_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q;
    logic [FW-1:0] frm_cnt_q;
    logic [AW-1:0] ack_cnt_q;
    logic [31:0]   adr_q, dat_q, rdata_q;
    logic [3:0]    sel_q;
    logic          wr_q;
    logic [7:0]    status_q;
    logic [2:0]    idx_q, last_q;

    logic cmd_ok, byte_last, frame_expired, ack_seen, ack_expired, tx_accept, resp_last;

    // The ack counter still holds its load value during the first stb cycle,
    // which is how that cycle is masked from ack sampling.
    assign cmd_ok        = cmd_valid(rx_data);
    assign byte_last     = (byte_cnt_q == 2'd3);
    assign frame_expired = (frm_cnt_q == '0);
    assign ack_seen      = ack_i && (ack_cnt_q != ACK_LOAD);
    assign ack_expired   = (ack_cnt_q == '0);
    assign tx_accept     = tx_valid && tx_ready;
    assign resp_last     = (idx_q == last_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; a byte arriving in the terminal frame-timer cycle wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_valid) state_d = cmd_ok ? ADDR : RESP;
            ADDR: begin
                if (rx_valid) begin
                    if (byte_last) state_d = wr_q ? WDATA : BUS;
                end else if (frame_expired) begin
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    if (byte_last) state_d = BUS;
                end else if (frame_expired) begin
                    state_d = IDLE;
                end
            end
            BUS:     if (ack_seen || ack_expired) state_d = RESP;
            RESP:    if (tx_accept && resp_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame capture, timers, bus result latching and response index.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            byte_cnt_q <= '0;
            frm_cnt_q  <= '0;
            ack_cnt_q  <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdata_q    <= '0;
            sel_q      <= '0;
            wr_q       <= 1'b0;
            status_q   <= '0;
            idx_q      <= '0;
            last_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        byte_cnt_q <= '0;
                        frm_cnt_q  <= FRM_LOAD;
                        idx_q      <= '0;
                        last_q     <= '0;
                        status_q   <= ST_NAK;
                        if (cmd_ok) begin
                            sel_q <= rx_data[7:4];
                            wr_q  <= (rx_data[1:0] == OP_WR);
                        end
                    end
                end
                ADDR, WDATA: begin
                    if (rx_valid) begin
                        if (state_q == ADDR) adr_q <= {adr_q[23:0], rx_data};
                        else                 dat_q <= {dat_q[23:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        frm_cnt_q  <= FRM_LOAD;
                        ack_cnt_q  <= ACK_LOAD;
                    end else if (!frame_expired) begin
                        frm_cnt_q <= frm_cnt_q - 1'b1;
                    end
                end
                BUS: begin
                    idx_q <= '0;
                    if (ack_seen) begin
                        status_q <= ST_ACK;
                        if (!wr_q) begin
                            rdata_q <= dat_i;
                            last_q  <= 3'd4;
                        end
                    end else if (ack_expired) begin
                        status_q <= ST_NAK;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 1'b1;
                    end
                end
                RESP:    if (tx_accept) idx_q <= idx_q + 3'd1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and the captured frame/response registers.
    always_comb begin
        busy_o   = (state_q != IDLE);
        stb_o    = (state_q == BUS);
        we_o     = (state_q == BUS) && wr_q;
        tx_valid = (state_q == RESP);
        rx_ovr_o = rst_i && rx_valid && ((state_q == BUS) || (state_q == RESP));
        adr_o    = adr_q;
        dat_o    = dat_q;
        sel_o    = sel_q;
        tx_data  = 8'h00;
        if (state_q == RESP) begin
            case (idx_q)
                3'd0:    tx_data = status_q;
                3'd1:    tx_data = rdata_q[31:24];
                3'd2:    tx_data = rdata_q[23:16];
                3'd3:    tx_data = rdata_q[15:8];
                3'd4:    tx_data = rdata_q[7:0];
                default: tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: table of directed frames, hand sequences for
// frame timeout, overrun and reset, and random frames against a frame-level
// reference model.
module tb_dbg_bus_master;

    logic        clk      = 1'b0;
    logic        rst_i    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] adr_o, dat_o;
    logic [31:0] dat_i    = 32'h0;
    logic [3:0]  sel_o;
    logic        we_o, stb_o, busy_o, rx_ovr_o;
    logic        ack_i    = 1'b0;

    int tests = 0;
    int fails = 0;

    int          ack_at  = 1;
    int          stall   = 0;
    logic [31:0] rd_word = 32'h0;
    int          scnt    = 0;
    int          wcnt    = 0;
    bit          tx_acc_prev = 1'b0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          len;
    } bus_t;

    bus_t        bq[$];
    logic [7:0]  txq[$];
    int          b_len = 0;
    bus_t        b_cur;
    int          bus_unstable = 0;
    int          tx_unstable  = 0;
    int          ovr_cnt      = 0;
    bit          txv_hold     = 1'b0;
    logic [7:0]  tx_hold      = 8'h00;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdat;
        int          ack;
        int          stl;
        int          gap;
        bit          e_bus;
        int          e_len;
        int          e_ntx;
        logic [39:0] e_tx;
    } vec_t;

    vec_t vt[8];

    dbg_bus_master #(.ACK_TIMEOUT(1024), .FRAME_TIMEOUT(100)) dut (
        .clk(clk), .rst_i(rst_i),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
        .we_o(we_o), .stb_o(stb_o), .ack_i(ack_i),
        .busy_o(busy_o), .rx_ovr_o(rx_ovr_o)
    );

    always #5 clk = ~clk;

    // Bus responder and transmitter sink, updated just after each rising edge.
    always begin
        @(posedge clk); #1;
        if (tx_acc_prev) wcnt = 0;
        scnt  = stb_o ? scnt + 1 : 0;
        ack_i = stb_o && (ack_at != 0) && (scnt >= ack_at);
        dat_i = (stb_o && scnt >= ((ack_at < 2) ? 2 : ack_at)) ? rd_word : 32'hBAD0_BAD0;
        if (tx_valid) begin
            tx_ready = (wcnt >= stall);
            wcnt++;
        end else begin
            tx_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor on the falling edge: bus cycles, accepted tx bytes, overruns.
    always @(negedge clk) begin
        tx_acc_prev = tx_valid && tx_ready;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (tx_valid && txv_hold && (tx_data != tx_hold)) tx_unstable++;
        txv_hold = tx_valid && !tx_ready;
        tx_hold  = tx_data;
        if (stb_o) begin
            if (b_len == 0) begin
                b_cur.adr = adr_o; b_cur.dat = dat_o; b_cur.sel = sel_o; b_cur.we = we_o;
            end else if ({adr_o, dat_o, sel_o, we_o} != {b_cur.adr, b_cur.dat, b_cur.sel, b_cur.we}) begin
                bus_unstable++;
            end
            b_len++;
        end else begin
            if (we_o) bus_unstable++;
            if (b_len != 0) begin
                b_cur.len = b_len;
                bq.push_back(b_cur);
                b_len = 0;
            end
        end
        if (rx_ovr_o) ovr_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        bq.delete();
        txq.delete();
        bus_unstable = 0;
        tx_unstable  = 0;
        ovr_cnt      = 0;
    endtask

    function automatic int frame_len(input logic [7:0] cmd);
        if (cmd[7:4] == 4'h0) return 1;
        if (cmd[1:0] == 2'b01) return 9;
        if (cmd[1:0] == 2'b10) return 5;
        return 1;
    endfunction

    function automatic logic [7:0] fbyte(input logic [7:0] cmd, input logic [31:0] adr,
                                         input logic [31:0] dat, input int i);
        logic [71:0] f;
        f = {cmd, adr, dat};
        return f[71-8*i -: 8];
    endfunction

    task automatic send_range(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                              input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            rx_data  = fbyte(cmd, adr, dat, i);
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (i != last) repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, busy_o, 0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                                input logic [31:0] dat, input bit e_bus, input int e_len,
                                input int e_ntx, input logic [39:0] e_tx);
        chk({tag, "_nbus"}, bq.size(), e_bus);
        if (e_bus && bq.size() != 0) begin
            chk({tag, "_adr"}, bq[0].adr, adr);
            chk({tag, "_sel"}, bq[0].sel, cmd[7:4]);
            chk({tag, "_we"}, bq[0].we, cmd[1:0] == 2'b01);
            chk({tag, "_len"}, bq[0].len, e_len);
            if (cmd[1:0] == 2'b01) chk({tag, "_dat"}, bq[0].dat, dat);
        end
        chk({tag, "_ntx"}, txq.size(), e_ntx);
        for (int i = 0; i < e_ntx; i++)
            chk($sformatf("%s_tx%0d", tag, i), (i < txq.size()) ? {56'h0, txq[i]} : 64'hFFFF,
                e_tx[39-8*i -: 8]);
        chk({tag, "_bus_stable"}, bus_unstable, 0);
        chk({tag, "_tx_stable"}, tx_unstable, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [31:0] rdat, input int ack,
                             input int stl, input int gap, input bit e_bus, input int e_len,
                             input int e_ntx, input logic [39:0] e_tx);
        clear_obs();
        ack_at  = ack;
        stall   = stl;
        rd_word = rdat;
        send_range(cmd, adr, dat, 0, frame_len(cmd) - 1, gap);
        chk({tag, "_stb_lat"}, stb_o, e_bus);
        wait_idle(tag, 3000);
        check_result(tag, cmd, adr, dat, e_bus, e_len, e_ntx, e_tx);
        chk({tag, "_ovr"}, ovr_cnt, 0);
    endtask

    initial begin
        int          n;
        int          r;
        logic [3:0]  sel;
        logic [1:0]  op;
        logic [7:0]  cmd;
        logic [31:0] adr, dat, rdat;
        int          ack, stl, gap;
        bit          valid, e_bus;
        int          e_len, e_ntx;
        logic [39:0] e_tx;

        //        cmd    adr           dat           rdat          ack stl gap bus len   ntx tx
        vt[0] = '{8'hF1, 32'h00000010, 32'hDEADBEEF, 32'h0,        3,  0,  0,  1,  3,    1,  40'h06_00000000};
        vt[1] = '{8'h32, 32'h01000000, 32'h0,        32'h0000005A, 1,  5,  1,  1,  2,    5,  40'h06_0000005A};
        vt[2] = '{8'hF2, 32'h05000000, 32'h0,        32'h0,        0,  0,  0,  1,  1024, 1,  40'h15_00000000};
        vt[3] = '{8'h03, 32'h0,        32'h0,        32'h0,        1,  0,  0,  0,  0,    1,  40'h15_00000000};
        vt[4] = '{8'hF3, 32'h0,        32'h0,        32'h0,        1,  0,  0,  0,  0,    1,  40'h15_00000000};
        vt[5] = '{8'h80, 32'h0,        32'h0,        32'h0,        1,  0,  0,  0,  0,    1,  40'h15_00000000};
        vt[6] = '{8'h12, 32'h89ABCDEF, 32'h0,        32'hA5C30F96, 5,  1,  2,  1,  5,    5,  40'h06_A5C30F96};
        vt[7] = '{8'h41, 32'hFFFFFFFC, 32'h12345678, 32'h0,        2,  2,  0,  1,  2,    1,  40'h06_00000000};

        // Reset values
        rst_i = 1'b0;
        repeat (3) tick();
        chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovr", rx_ovr_o, 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_txd", tx_data, 0);
        rst_i = 1'b1;
        repeat (2) tick();

        // Directed table
        for (int v = 0; v < 8; v++)
            run_frame($sformatf("v%0d", v), vt[v].cmd, vt[v].adr, vt[v].dat, vt[v].rdat,
                      vt[v].ack, vt[v].stl, vt[v].gap, vt[v].e_bus, vt[v].e_len,
                      vt[v].e_ntx, vt[v].e_tx);

        // Frame timeout: silent return to IDLE exactly 100 idle cycles after a byte
        clear_obs();
        ack_at = 2; stall = 0;
        send_range(8'hF1, 32'h00000010, 32'hDEADBEEF, 0, 2, 0);
        repeat (99) tick();
        chk("fto_busy_terminal", busy_o, 1);
        tick();
        chk("fto_idle", busy_o, 0);
        repeat (5) tick();
        chk("fto_no_tx", txq.size(), 0);
        chk("fto_no_bus", bq.size(), 0);
        run_frame("after_abort", 8'h32, 32'h01000000, 32'h0, 32'h0000005A, 1, 0, 0,
                  1, 2, 5, 40'h06_0000005A);

        // A byte arriving in the terminal timer cycle is consumed, frame continues
        clear_obs();
        ack_at = 2; stall = 0;
        send_range(8'hF1, 32'h00000010, 32'hDEADBEEF, 0, 2, 0);
        repeat (99) tick();
        send_range(8'hF1, 32'h00000010, 32'hDEADBEEF, 3, 8, 0);
        chk("fto_term_stb", stb_o, 1);
        wait_idle("fto_term", 3000);
        check_result("fto_term", 8'hF1, 32'h00000010, 32'hDEADBEEF, 1, 2, 1, 40'h06_00000000);

        // Overrun: bytes during BUS and RESP are dropped and flagged
        clear_obs();
        ack_at = 3; stall = 4; rd_word = 32'hC0FFEE11;
        send_range(8'h52, 32'h00000100, 32'h0, 0, 4, 0);
        rx_data = 8'hAA; rx_valid = 1'b1; #1;
        chk("ovr_pulse_bus", rx_ovr_o, 1);
        tick();
        rx_valid = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin tick(); n++; end
        chk("ovr_resp_reached", tx_valid, 1);
        rx_data = 8'hBB; rx_valid = 1'b1; #1;
        chk("ovr_pulse_resp", rx_ovr_o, 1);
        tick();
        rx_valid = 1'b0;
        wait_idle("ovr", 3000);
        check_result("ovr", 8'h52, 32'h00000100, 32'h0, 1, 3, 5, 40'h06_C0FFEE11);
        chk("ovr_count", ovr_cnt, 2);

        // Reset during the second stb cycle: bus dropped, no response
        clear_obs();
        ack_at = 0; stall = 0; rd_word = 32'h0;
        send_range(8'h22, 32'h00000040, 32'h0, 0, 4, 0);
        chk("mrst_stb_c1", stb_o, 1);
        tick();
        chk("mrst_stb_c2", stb_o, 1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("mrst_stb", stb_o, 0);
        chk("mrst_txv", tx_valid, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_adr", adr_o, 0);
        repeat (20) tick();
        chk("mrst_no_tx", txq.size(), 0);
        chk("mrst_still_idle", busy_o, 0);

        // Random frames against the frame-level model
        for (int k = 0; k < 24; k++) begin
            r    = int'($urandom_range(0, 9));
            sel  = (r == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (r == 1) op = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            else        op = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            cmd  = {sel, 2'($urandom_range(0, 3)), op};
            adr  = $urandom;
            dat  = $urandom;
            rdat = $urandom;
            ack  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
            stl  = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 2));
            valid = (sel != 4'h0) && (op == 2'b01 || op == 2'b10);
            e_bus = valid;
            e_len = !valid ? 0 : (ack == 0) ? 1024 : (ack < 2) ? 2 : ack;
            if (!valid || ack == 0) begin
                e_ntx = 1; e_tx = {8'h15, 32'h0};
            end else if (op == 2'b01) begin
                e_ntx = 1; e_tx = {8'h06, 32'h0};
            end else begin
                e_ntx = 5; e_tx = {8'h06, rdat};
            end
            run_frame($sformatf("r%0d", k), cmd, adr, dat, rdat, ack, stl, gap,
                      e_bus, e_len, e_ntx, e_tx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbg_bus_master.md
Name: dbg_bus_master

Overview:
Byte-stream-controlled bus initiator. Lets a host drive the on-chip stb/ack bus (adr/dat/sel/we), so it can peek and poke RAM, LED and peripheral banks without the CPU. It consumes command bytes from a byte receiver and issues single bus cycles. It returns status and read data through a byte transmitter handshake. Top-level muxes its bus outputs against the CPU's, using busy_o as the grant request.

Parameters:
ACK_TIMEOUT, 1024, max cycles stb_o is held awaiting ack_i before the cycle is aborted
FRAME_TIMEOUT, 2500000, max idle cycles between bytes of one command frame (100 ms at 25 MHz)

Ports:
clk  in  1  system clock
rst_i  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready
adr_o  out  32  bus address
dat_o  out  32  bus write data
dat_i  in  32  bus read data
sel_o  out  4  byte lane enables
we_o  out  1  1 = write cycle
stb_o  out  1  bus strobe
ack_i  in  1  bus acknowledge
busy_o  out  1  high whenever state != IDLE
rx_ovr_o  out  1  one-cycle pulse: rx byte dropped

Behaviour:
- Reset (rst_i=0): state IDLE; stb_o=0, we_o=0, tx_valid=0, rx_ovr_o=0, busy_o=0, adr_o=0, dat_o=0, sel_o=0, tx_data=0. All counters are cleared. A reset during a bus cycle drops stb_o on the next edge, with no response.
- Frame layout: cmd byte, then 4 address bytes MSB first. A write adds 4 data bytes MSB first.
- cmd[7:4] = sel, cmd[1:0] = op: 01 write, 10 read. Any other op, or sel=0, is invalid.
- States: IDLE -> ADDR (4 bytes) -> [WDATA (4 bytes), writes only] -> BUS -> RESP -> IDLE.
- An invalid cmd goes IDLE -> RESP with status NAK (0x15).
- Byte counter is 2 bits. Each byte shifts into adr_o/dat_o from the LSB end. adr_o, dat_o and sel_o are stable throughout BUS.
- BUS entry: stb_o=1; we_o=1 for write, 0 for read.
  - ack_i is ignored in the first stb_o cycle and sampled from the second cycle onward. This gives a minimum 2-cycle bus cycle, so registered-data responders are covered.
  - On the first sampled ack_i=1: a read latches dat_i. stb_o and we_o deassert on the next edge, then state goes to RESP with status ACK (0x06).
  - If ack_i is not seen after ACK_TIMEOUT stb cycles: stb_o drops and state goes to RESP with status NAK.
- RESP: sends status; a successful read then sends 4 data bytes MSB first.
  - Each byte is presented with tx_valid=1 and held stable until tx_valid&tx_ready.
  - The next byte is presented in the cycle after acceptance, or tx_valid drops after the last byte. Then state returns to IDLE.
- rx_valid while in BUS or RESP: byte discarded, rx_ovr_o pulses in the same cycle. In IDLE/ADDR/WDATA every rx byte is consumed.
- Frame timeout: in ADDR/WDATA, FRAME_TIMEOUT cycles without rx_valid returns to IDLE silently. The counter restarts on every consumed byte. rx_valid in the exact terminal cycle wins (byte consumed, no abort).
- Counters saturate/clear on state entry; no wrap-around reaches a terminal value spuriously.
- Latency: the last frame byte causes stb_o=1 on the next cycle.

Decomposition:
- Package dbg_bus_pkg holds:
  - op codes: OP_WR=2'b01, OP_RD=2'b10
  - status codes: ST_ACK=8'h06, ST_NAK=8'h15
  - the state enum: IDLE, ADDR, WDATA, BUS, RESP
- Single module, one FSM. No sub-module; the response byte sequencer is a 3-bit index inside RESP.

Test Plan:
- Write: bytes F1 00 00 00 10 DE AD BE EF; responder acks in stb cycle 3 -> stb_o with adr_o=0x00000010, dat_o=0xDEADBEEF, sel_o=F, we_o=1 for 3 cycles; then tx 06.
- Read: bytes 32 01 00 00 00; ack_i tied to stb_o, dat_i=0x0000005A from cycle 2 -> stb_o exactly 2 cycles, we_o=0, sel_o=3; tx 06 00 00 00 5A. With tx_ready stalled 5 cycles per byte, tx_data stays stable.
- Timeout: read F2 05 00 00 00, no ack -> stb_o high for 1024 cycles, then 0; tx 15 only.
- Invalid: cmd 03 (sel=0), then cmd F3 -> tx 15 each, bus untouched; busy_o returns 0.
- Frame abort: F1 00 00, silence of FRAME_TIMEOUT (set to 100) -> IDLE, no tx. Then a full read frame completes normally. Also send bytes during BUS -> rx_ovr_o pulses, response unaffected.
- Reset: rst_i=0 for 1 cycle during the 2nd stb cycle -> stb_o=0, tx_valid=0 next edge; no response emitted.
